// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scanner.
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  typedef logic [3:0] key_code_t;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
  typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} frame_t;
endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: 2-flop synchroniser for the asynchronous column lines.
module keypad_col_sync
  import keypad_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [COLS-1:0] d,
  output logic [COLS-1:0] q
);
  logic [COLS-1:0] meta;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scan, frame-level debounce and ghost rejection.
// Define KEYPAD_REPEAT_EN to emit auto-repeat events while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 8,
  parameter int REPEAT_FRAMES   = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [COLS-1:0] col_n,
  input  logic            inhibit,
  output logic [ROWS-1:0] row_n,
  output key_code_t       key_code,
  output logic            key_valid,
  output logic            key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] DONE = CW'(DEBOUNCE_FRAMES);
  logic [DW-1:0] div;
  logic [1:0] row, acc_cnt, slot_cnt;
  logic [COLS-1:0] col_s;
  key_code_t acc_code, slot_code, cand, cand_n;
  state_t state, state_n;
  frame_t f_res;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic slot_end, frame_end, hit, same_cand, ev_q, ev_n;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep, rep_n, rep_inc;
  assign rep_inc = (rep == RW'(REPEAT_FRAMES)) ? rep : rep + 1'b1;
`endif

  keypad_col_sync u_sync (.clk(clk), .reset_n(reset_n), .d(col_n), .q(col_s));

  assign slot_end  = div == DW'(SCAN_DIV - 1);
  assign frame_end = slot_end && row == 2'd3;
  assign row_n     = ~(ROWS'(1) << row);
  assign key_valid = ev_q & ~inhibit;
  assign key_held  = state == HELD || state == REL_DB;

  // Key count saturates at 2: anything beyond one key is a ghost-prone MULTI frame.
  always_comb begin
    slot_cnt  = acc_cnt;
    slot_code = acc_code;
    for (int c = 0; c < COLS; c++)
      if (!col_s[c]) begin
        slot_cnt  = (slot_cnt == 2'd2) ? 2'd2 : slot_cnt + 2'd1;
        slot_code = {row, 2'(c)};
      end
  end

  assign f_res     = (slot_cnt == 2'd0) ? F_NONE : (slot_cnt == 2'd1) ? F_SINGLE : F_MULTI;
  assign hit       = f_res == F_SINGLE;
  assign same_cand = hit && slot_code == cand;
  assign cnt_inc   = (cnt == DONE) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    ev_n    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_n   = rep;
`endif
    if (frame_end)
      case (state)
        IDLE:
          if (hit) begin
            cand_n = slot_code;
            cnt_n  = CW'(1);
            ev_n   = DEBOUNCE_FRAMES == 1;
            if (DEBOUNCE_FRAMES == 1) state_n = HELD;
            else state_n = PRESS_DB;
          end
        PRESS_DB:
          if (same_cand) begin
            cnt_n = cnt_inc;
            ev_n  = cnt_inc == DONE;
            if (cnt_inc == DONE) state_n = HELD;
          end else if (hit) begin
            cand_n = slot_code;
            cnt_n  = CW'(1);
          end else state_n = IDLE;
        HELD:
          if (!same_cand) begin
            cnt_n = CW'(1);
            if (DEBOUNCE_FRAMES == 1) state_n = IDLE;
            else state_n = REL_DB;
`ifdef KEYPAD_REPEAT_EN
            rep_n = '0;
          end else begin
            ev_n  = rep_inc == RW'(REPEAT_FRAMES);
            rep_n = ev_n ? '0 : rep_inc;
`endif
          end
        REL_DB:
          if (same_cand) state_n = HELD;
          else begin
            cnt_n = cnt_inc;
            if (cnt_inc == DONE) state_n = IDLE;
          end
        default: state_n = IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div      <= '0;
      row      <= '0;
      acc_cnt  <= '0;
      acc_code <= '0;
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      ev_q     <= 1'b0;
      key_code <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep      <= '0;
`endif
    end else begin
      div <= slot_end ? '0 : div + 1'b1;
      if (slot_end) begin
        row      <= row + 2'd1;
        acc_cnt  <= frame_end ? 2'd0 : slot_cnt;
        acc_code <= slot_code;
      end
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
      ev_q  <= ev_n;
      if (ev_n) key_code <= cand_n;
`ifdef KEYPAD_REPEAT_EN
      rep <= rep_n;
`endif
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: random and directed frames against a frame-level keypad model.
module tb_keypad_scanner;
  localparam int SD = 4, DEB = 3, REP = 4, HALF = 5, FRAME = 4 * SD;
  logic clk = 1'b0, reset_n = 1'b1, inhibit = 1'b0, started = 1'b0;
  logic [3:0] col_n, row_n, key_code;
  logic key_valid, key_held;
  logic [15:0] keys = '0;
  int vectors = 0, miscompares = 0;
  typedef struct {int code; time t;} ev_t;
  ev_t exp_q[$];
  int res[$];
  int held = -1, rel_f = -1, acc_f = 0, streak = 0, last_code = 0;

  always #HALF clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DEB), .REPEAT_FRAMES(REP)) dut (
    .clk(clk), .reset_n(reset_n), .col_n(col_n), .inhibit(inhibit),
    .row_n(row_n), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // Passive matrix: a column reads low when a pressed key sits on a driven row.
  always_comb begin
    col_n = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (started) begin
      if (exp_q.size() != 0 && $time == exp_q[0].t + HALF) begin
        check("event_valid", key_valid, 1);
        check("event_code", key_code, exp_q[0].code);
        void'(exp_q.pop_front());
      end else check("quiet_valid", key_valid, 0);
    end

  task automatic emit(input int code, input logic inh);
    ev_t e;
    e.code = code;
    e.t = $time;
    if (!inh) exp_q.push_back(e);
  endtask

  task automatic frame(input logic [15:0] k, input logic inh);
    int r, f;
    logic rel, acc;
    keys = k;
    inhibit = inh;
    repeat (FRAME) @(posedge clk);
    r = -1;
    for (int i = 0; i < 16; i++) if (k == 16'(1) << i) r = i;
    res.push_back(r);
    f = res.size() - 1;
    if (held >= 0) begin
      rel = 1'b1;
      for (int i = 0; i < DEB; i++) if (f - i < 0 || res[f-i] == held) rel = 1'b0;
      if (rel) begin
        held = -1;
        rel_f = f;
        streak = 0;
      end
`ifdef KEYPAD_REPEAT_EN
      else if (r == held && f - 1 >= acc_f && res[f-1] == held) begin
        streak++;
        if (streak == REP) begin
          streak = 0;
          emit(held, inh);
        end
      end else streak = 0;
`endif
    end else begin
      acc = r >= 0 && f - DEB + 1 > rel_f;
      for (int i = 0; i < DEB; i++) if (acc && res[f-i] != r) acc = 1'b0;
      if (acc) begin
        held = r;
        acc_f = f;
        streak = 0;
        last_code = r;
        emit(r, inh);
      end
    end
    @(negedge clk);
    #1;
    check("key_held", key_held, held >= 0);
    check("key_code_hold", key_code, last_code);
  endtask

  task automatic frames(input int n, input logic [15:0] k, input logic inh);
    for (int i = 0; i < n; i++) frame(k, inh);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_row_n", row_n, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    res.delete();
    exp_q.delete();
    held = -1;
    rel_f = -1;
    streak = 0;
    last_code = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] k;
    int a, b;
    repeat (2) @(negedge clk);
    #1;
    do_reset();
    started = 1'b1;
    frames(5, 16'(1) << 9, 1'b0);
    frames(4, '0, 1'b0);
    for (int i = 0; i < 6; i++) frame(i % 2 ? '0 : 16'(1) << 9, 1'b0);
    frames(3, '0, 1'b0);
    frames(6, (16'(1) << 9) | (16'(1) << 10), 1'b0);
    frames(4, 16'(1) << 9, 1'b0);
    frames(4, '0, 1'b0);
    frames(5, 16'(1) << 5, 1'b1);
    frames(2, 16'(1) << 5, 1'b0);
    frames(4, '0, 1'b0);
    frames(4, 16'(1) << 9, 1'b0);
    do_reset();
    frames(4, 16'(1) << 9, 1'b0);
    frames(4, '0, 1'b0);
`ifdef KEYPAD_REPEAT_EN
    frames(15, 16'(1) << 3, 1'b0);
    frames(4, '0, 1'b0);
`endif
    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case ($urandom_range(0, 3))
        0: k = '0;
        1: k = (16'(1) << a) | (16'(1) << b);
        default: k = 16'(1) << a;
      endcase
      frames($urandom_range(1, 5), k, $urandom_range(0, 3) == 0);
    end
    frames(4, '0, 1'b0);
    check("pending_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 matrix keypad, synchronises and debounces the column lines, and delivers one clean key event per press to the game module. It sits directly upstream of the game logic. `key_code` drives the game's `keypad_input`, and `key_valid` drives its `keypad_enable`. It also rejects multi-key presses and suppresses events while the game is playing back music.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per row slot; must be >= 4.
- `DEBOUNCE_FRAMES`, default 8: consecutive identical scan frames needed to accept a press or a release; must be >= 1.
- `REPEAT_FRAMES`, default 64: frames between auto-repeat events; used only with `KEYPAD_REPEAT_EN`.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `col_n` in 4: keypad column lines, active-low, asynchronous to `clk`.
- `inhibit` in 1: high while the game is playing music; blocks `key_valid`.
- `row_n` out 4: row drive, one-hot active-low.
- `key_code` out 4: accepted key, equal to `{row[1:0], col[1:0]}`.
- `key_valid` out 1: one-cycle pulse when a key event is emitted.
- `key_held` out 1: high while the accepted key remains debounced-pressed.

## Operation
- `col_n` passes through a 2-flop synchroniser before any use.
- Row counter:
  - Advances 0→1→2→3→0 every `SCAN_DIV` cycles.
  - `row_n` = ~(1 << row).
  - Synchronised columns are sampled in the last cycle of each slot.
- Frame: the 4 slots of rows 0–3. At frame end the frame result is:
  - NONE: no column low in any row.
  - SINGLE(code): exactly one key low across the frame.
  - MULTI: more than one key low. MULTI is treated as NONE (ghost rejection).
- FSM states are IDLE, PRESS_DB, HELD, REL_DB. All transitions are evaluated only at frame end:
  - IDLE: SINGLE(c) → PRESS_DB, cand=c, cnt=1. If `DEBOUNCE_FRAMES`=1, go straight to HELD with an event.
  - PRESS_DB:
    - SINGLE(cand) → cnt+1; when cnt reaches `DEBOUNCE_FRAMES`, go to HELD and emit an event.
    - SINGLE(other) → cand=other, cnt=1.
    - NONE/MULTI → IDLE.
  - HELD:
    - Any frame other than SINGLE(`key_code`) → REL_DB, cnt=1.
    - Otherwise stay in HELD.
  - REL_DB:
    - A non-held frame → cnt+1; when cnt reaches `DEBOUNCE_FRAMES`, go to IDLE.
    - SINGLE(`key_code`) → HELD, with no new event.
- Event: the cycle after the frame-end evaluation, `key_code` is loaded with cand. `key_valid` pulses for exactly one cycle in that same cycle, unless `inhibit` is high then.
- A press that completes debounce while `inhibit` is high is never reported, including after `inhibit` falls. `key_held` still follows the FSM.
- `key_held` is 1 in HELD and REL_DB, and 0 otherwise.
- `key_code` holds its last value until the next event.
- Counters are sized with `$clog2` of their parameter and saturate; they never wrap.

## Timing
- Reset values: `row_n`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, FSM=IDLE, all counters 0.
- Frame length is 4·`SCAN_DIV` cycles.
- Press latency is `DEBOUNCE_FRAMES` frames from the first full frame in which the key is seen, plus 1 cycle. The synchroniser adds 2 cycles, which is covered by sampling at the end of each slot.
- `key_valid` is never high on two consecutive cycles.
- Reset asserted mid-operation returns everything to the reset values immediately. No event is emitted on reset release.

## Configuration
- `KEYPAD_REPEAT_EN` defined: while in HELD, an event with the same `key_code` is emitted every `REPEAT_FRAMES` frames after acceptance. The repeat counter clears on leaving HELD. `inhibit` also masks repeats.
- `KEYPAD_REPEAT_EN` undefined: exactly one event per press, and there is no repeat logic.

## Structure
- `keypad_pkg` holds:
  - The FSM state enum.
  - The frame-result enum (NONE, SINGLE, MULTI).
  - A `key_code_t` 4-bit typedef.
  - Row count and column count constants (4, 4).
- `keypad_col_sync` is a 2-flop, 4-bit synchroniser sub-module with async active-low reset. It resets to 4'b1111.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_FRAMES`=3, giving a 16-cycle frame.
- Hold row 2 / col 1 low for 5 frames → one `key_valid` pulse 1 cycle after the end of frame 3, with `key_code`=9. `key_held`=1 until 3 frames after release.
- Key 9 bounces on/off on alternate frames for 6 frames, then releases → no `key_valid`; `key_held` stays 0.
- Keys 9 and 10 are held together for 6 frames → no event. Release key 10 → event with code 9 after 3 more frames.
- `inhibit`=1 while key 5 is held 5 frames, then `inhibit`→0 while the key is still held → no `key_valid` at any time; `key_held`=1.
- `reset_n` is pulsed low while in HELD with key 9 → `row_n`=1110 and all outputs are 0 at once. The key is still held after reset release → a fresh event after 3 frames.
- With `KEYPAD_REPEAT_EN` and `REPEAT_FRAMES`=4, hold key 3 for 15 frames → events at frames 3, 7, 11 and 15, all with code 3.
